// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory port between the sequencer and the memory.
//   mem_req   : sequencer -> memory, request pending (held until mem_ready)
//   mem_we    : sequencer -> memory, 1 = write, 0 = read
//   iord      : sequencer -> memory, address select (0 = PC, 1 = ALU result)
//   mem_ready : memory -> sequencer, transfer completes on this cycle's edge
interface multicycle_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle Moore control sequencer for the CORG processor.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB, drives datapath
// mux selects and strobes, counts retired instructions and traps on
// undefined opcodes.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   mem             : memory handshake (master side)
//   opcode          : IR opcode, sampled in DECODE only
//   alu_zero        : ALU zero flag, used in EXECUTE of beq/bne
//   ir_write .. reg_write : datapath control
//   retire          : one-cycle pulse per completed instruction
//   instr_count     : retired-instruction count (wraps)
//   trap            : sticky undefined-opcode flag
//   state           : current state, for debug
module multicycle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_sequencer_if.master mem,
    input  logic [4:0]           opcode,
    input  logic                 alu_zero,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_src,
    output logic [2:0]           alu_op,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 reg_write,
    output logic                 retire,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 trap,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_BAD
    } iclass_t;

    function automatic iclass_t classify(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00100, 5'b01000, 5'b01100,
            5'b10000, 5'b11000, 5'b11100: classify = C_R;
            5'b00010, 5'b00110, 5'b01010, 5'b01110: classify = C_I;
            5'b11010: classify = C_LW;
            5'b11110: classify = C_SW;
            5'b10010: classify = C_BEQ;
            5'b10110: classify = C_BNE;
            5'b00001: classify = C_J;
            5'b00101: classify = C_JAL;
            5'b10101: classify = C_JR;
            default:  classify = C_BAD;
        endcase
    endfunction

    function automatic logic [2:0] alu_fn(input logic [4:0] op);
        case (op)
            5'b00100, 5'b00110: alu_fn = 3'b001;
            5'b01000, 5'b01010: alu_fn = 3'b010;
            5'b01100, 5'b01110: alu_fn = 3'b011;
            5'b10000:           alu_fn = 3'b100;
            5'b11000:           alu_fn = 3'b110;
            5'b11100:           alu_fn = 3'b111;
            5'b10010, 5'b10110: alu_fn = 3'b010;
            default:            alu_fn = 3'b000;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [4:0]       opc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             trap_q;
    iclass_t          cls_q;

    logic       req_c, we_c, iord_c, irw_c, pcw_c, alusrc_c, rw_c, ret_c;
    logic [1:0] pcsrc_c, rdst_c, m2r_c;
    logic [2:0] aluop_c;

    assign cls_q = classify(opc_q);

    always_comb begin
        state_d  = state_q;
        req_c    = 1'b0;
        we_c     = 1'b0;
        iord_c   = 1'b0;
        irw_c    = 1'b0;
        pcw_c    = 1'b0;
        pcsrc_c  = 2'b00;
        alusrc_c = 1'b0;
        aluop_c  = 3'b000;
        rdst_c   = 2'b00;
        m2r_c    = 2'b00;
        rw_c     = 1'b0;
        ret_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem.mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (classify(opcode) == C_BAD) ? S_TRAP : S_EXECUTE;
            end
            S_EXECUTE: begin
                alusrc_c = (cls_q == C_I) || (cls_q == C_LW) || (cls_q == C_SW);
                aluop_c  = alu_fn(opc_q);
                case (cls_q)
                    C_R, C_I:   state_d = S_WB;
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ, C_BNE: begin
                        pcsrc_c = 2'b01;
                        pcw_c   = (cls_q == C_BEQ) ? alu_zero : ~alu_zero;
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_J, C_JAL: begin
                        pcsrc_c = 2'b10;
                        pcw_c   = 1'b1;
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
                        if (cls_q == C_JAL) begin
                            rw_c   = 1'b1;
                            rdst_c = 2'b10;
                            m2r_c  = 2'b10;
                        end
                    end
                    C_JR: begin
                        pcsrc_c = 2'b11;
                        pcw_c   = 1'b1;
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                req_c    = 1'b1;
                iord_c   = 1'b1;
                we_c     = (cls_q == C_SW);
                alusrc_c = 1'b1;
                if (mem.mem_ready) begin
                    if (cls_q == C_SW) begin
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rw_c     = 1'b1;
                alusrc_c = (cls_q == C_I) || (cls_q == C_LW);
                aluop_c  = alu_fn(opc_q);
                rdst_c   = (cls_q == C_R) ? 2'b01 : 2'b00;
                m2r_c    = (cls_q == C_LW) ? 2'b01 : 2'b00;
                ret_c    = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            opc_q   <= '0;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) opc_q <= opcode;
            if (ret_c) cnt_q <= cnt_q + CNT_W'(1);
            if (state_d == S_TRAP) trap_q <= 1'b1;
        end
    end

    // Every output is gated by rst so a pending request drops in the reset
    // cycle itself rather than one cycle later.
    assign mem.mem_req = req_c & ~rst;
    assign mem.mem_we  = we_c & ~rst;
    assign mem.iord    = iord_c & ~rst;
    assign ir_write    = irw_c & ~rst;
    assign pc_write    = pcw_c & ~rst;
    assign pc_src      = rst ? '0 : pcsrc_c;
    assign alu_src     = alusrc_c & ~rst;
    assign alu_op      = rst ? '0 : aluop_c;
    assign reg_dst     = rst ? '0 : rdst_c;
    assign mem_to_reg  = rst ? '0 : m2r_c;
    assign reg_write   = rw_c & ~rst;
    assign retire      = ret_c & ~rst;
    assign instr_count = rst ? '0 : cnt_q;
    assign trap        = trap_q & ~rst;
    assign state       = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a table of instruction
// vectors walked cycle by cycle, a scoreboard of expected retire latency and
// count, plus hand-written trap, wait-state, wrap and reset sequences.
module tb_multicycle_sequencer;

    localparam int TB_CNT_W = 8;
    localparam int P_WB = 0, P_LW = 1, P_SW = 2, P_EX = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [4:0]          opcode = 5'b0;
    logic                alu_zero = 1'b0;
    logic                ir_write, pc_write, alu_src, reg_write, retire, trap;
    logic [1:0]          pc_src, reg_dst, mem_to_reg;
    logic [2:0]          alu_op, state;
    logic [TB_CNT_W-1:0] instr_count;

    multicycle_sequencer_if mif();

    multicycle_sequencer #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .mem(mif), .opcode(opcode), .alu_zero(alu_zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retire(retire),
        .instr_count(instr_count), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op;
        logic       z;
        int         path;
        logic       asrc;
        logic [2:0] aop;
        logic       ex_pcw;
        logic [1:0] ex_pcsrc;
        logic       ex_rw;
        logic [1:0] ex_rdst;
        logic [1:0] ex_m2r;
        logic [1:0] wb_rdst;
        logic [1:0] wb_m2r;
        int         cpi;
    } vec_t;

    typedef struct {
        int                  cycles;
        logic [TB_CNT_W-1:0] count;
    } sb_t;

    vec_t                tbl[$];
    sb_t                 sbq[$];
    int                  n_vec = 0;
    int                  n_err = 0;
    int                  cyc = 0;
    logic [4:0]          cur_op = 5'b0;
    logic [TB_CNT_W-1:0] exp_count = '0;

    localparam logic [4:0] BAD_OP = 5'b00011;

    function automatic vec_t mk(input logic [4:0] op, input logic z, input int path,
                                input logic asrc, input logic [2:0] aop,
                                input logic ex_pcw, input logic [1:0] ex_pcsrc,
                                input logic ex_rw, input logic [1:0] ex_rdst,
                                input logic [1:0] ex_m2r, input logic [1:0] wb_rdst,
                                input logic [1:0] wb_m2r, input int cpi);
        vec_t v;
        v.op = op; v.z = z; v.path = path; v.asrc = asrc; v.aop = aop;
        v.ex_pcw = ex_pcw; v.ex_pcsrc = ex_pcsrc; v.ex_rw = ex_rw;
        v.ex_rdst = ex_rdst; v.ex_m2r = ex_m2r; v.wb_rdst = wb_rdst;
        v.wb_m2r = wb_m2r; v.cpi = cpi;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (op=%b, t=%0t): got %0h, expected %0h", nm, cur_op, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic finish_retire();
        sb_t e;
        step();
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sbq.pop_front();
            chk("cycles_per_instr", cyc, e.cycles);
            chk("instr_count", instr_count, e.count);
            exp_count = e.count;
        end
        chk("back_to_fetch", state, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mif.mem_ready = 1'b1;
        opcode = BAD_OP;
        step();
        step();
        chk("rst_state", state, 0);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_trap", trap, 0);
        chk("rst_irw", ir_write, 0);
        rst = 1'b0;
        exp_count = '0;
        sbq.delete();
    endtask

    task automatic run_instr(input vec_t v, input int fw, input int mw);
        sb_t e;
        cur_op = v.op;
        cyc = 0;
        e.cycles = v.cpi + fw + mw;
        e.count = exp_count + 1'b1;
        sbq.push_back(e);
        opcode = BAD_OP;  // only DECODE may sample the opcode
        for (int i = 0; i < fw; i++) begin
            mif.mem_ready = 1'b0; #1;
            chk("fetch_wait_state", state, 0);
            chk("fetch_wait_req", mif.mem_req, 1);
            chk("fetch_wait_we", mif.mem_we, 0);
            chk("fetch_wait_iord", mif.iord, 0);
            chk("fetch_wait_irw", ir_write, 0);
            step();
        end
        mif.mem_ready = 1'b1; #1;
        chk("fetch_state", state, 0);
        chk("fetch_req", mif.mem_req, 1);
        chk("fetch_iord", mif.iord, 0);
        chk("fetch_irw", ir_write, 1);
        chk("fetch_pcw", pc_write, 1);
        chk("fetch_pcsrc", pc_src, 0);
        chk("fetch_retire", retire, 0);
        step();
        opcode = v.op; #1;
        chk("decode_state", state, 1);
        chk("decode_req", mif.mem_req, 0);
        chk("decode_strobes", {ir_write, pc_write, reg_write, retire}, 0);
        step();
        opcode = BAD_OP;
        alu_zero = v.z; #1;
        chk("exec_state", state, 2);
        chk("exec_alu_src", alu_src, v.asrc);
        chk("exec_alu_op", alu_op, v.aop);
        chk("exec_pc_write", pc_write, v.ex_pcw);
        chk("exec_pc_src", pc_src, v.ex_pcsrc);
        chk("exec_reg_write", reg_write, v.ex_rw);
        chk("exec_reg_dst", reg_dst, v.ex_rdst);
        chk("exec_mem_to_reg", mem_to_reg, v.ex_m2r);
        chk("exec_req", mif.mem_req, 0);
        chk("exec_retire", retire, v.path == P_EX);
        if (v.path == P_EX) begin
            finish_retire();
            return;
        end
        step();
        alu_zero = ~v.z;
        if (v.path == P_LW || v.path == P_SW) begin
            for (int i = 0; i <= mw; i++) begin
                mif.mem_ready = (i == mw); #1;
                chk("mem_state", state, 3);
                chk("mem_req", mif.mem_req, 1);
                chk("mem_iord", mif.iord, 1);
                chk("mem_we", mif.mem_we, v.path == P_SW);
                chk("mem_alu", {alu_src, alu_op}, 4'b1000);
                chk("mem_reg_write", reg_write, 0);
                chk("mem_retire", retire, (i == mw) && (v.path == P_SW));
                if (i < mw) step();
            end
            if (v.path == P_SW) begin
                finish_retire();
                return;
            end
            step();
        end
        mif.mem_ready = 1'b1; #1;
        chk("wb_state", state, 4);
        chk("wb_reg_write", reg_write, 1);
        chk("wb_reg_dst", reg_dst, v.wb_rdst);
        chk("wb_mem_to_reg", mem_to_reg, v.wb_m2r);
        chk("wb_alu", {alu_src, alu_op}, {v.asrc, v.aop});
        chk("wb_pc_write", pc_write, 0);
        chk("wb_req", mif.mem_req, 0);
        chk("wb_retire", retire, 1);
        finish_retire();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vj;
        mif.mem_ready = 1'b0;

        //          op        z  path  as aop     pcw pcs   rw rdst   m2r    wbrd   wbm2r  cpi
        tbl.push_back(mk(5'b00000, 0, P_WB, 0, 3'b000, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4));
        tbl.push_back(mk(5'b00100, 0, P_WB, 0, 3'b001, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4));
        tbl.push_back(mk(5'b01000, 0, P_WB, 0, 3'b010, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4));
        tbl.push_back(mk(5'b01100, 1, P_WB, 0, 3'b011, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4));
        tbl.push_back(mk(5'b10000, 0, P_WB, 0, 3'b100, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4));
        tbl.push_back(mk(5'b11000, 0, P_WB, 0, 3'b110, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4));
        tbl.push_back(mk(5'b11100, 0, P_WB, 0, 3'b111, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, 4));
        tbl.push_back(mk(5'b00010, 0, P_WB, 1, 3'b000, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4));
        tbl.push_back(mk(5'b00110, 0, P_WB, 1, 3'b001, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4));
        tbl.push_back(mk(5'b01010, 0, P_WB, 1, 3'b010, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4));
        tbl.push_back(mk(5'b01110, 1, P_WB, 1, 3'b011, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4));
        tbl.push_back(mk(5'b11010, 0, P_LW, 1, 3'b000, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b01, 5));
        tbl.push_back(mk(5'b11110, 0, P_SW, 1, 3'b000, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4));
        tbl.push_back(mk(5'b10010, 1, P_EX, 0, 3'b010, 1, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3));
        tbl.push_back(mk(5'b10010, 0, P_EX, 0, 3'b010, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3));
        tbl.push_back(mk(5'b10110, 1, P_EX, 0, 3'b010, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3));
        tbl.push_back(mk(5'b10110, 0, P_EX, 0, 3'b010, 1, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3));
        tbl.push_back(mk(5'b00001, 0, P_EX, 0, 3'b000, 1, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3));
        tbl.push_back(mk(5'b00101, 0, P_EX, 0, 3'b000, 1, 2'b10, 1, 2'b10, 2'b10, 2'b00, 2'b00, 3));
        tbl.push_back(mk(5'b10101, 1, P_EX, 0, 3'b000, 1, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3));

        do_reset();
        foreach (tbl[i]) run_instr(tbl[i], 0, 0);

        // Memory wait states: lw with 2 MEM waits (7 cycles), sw with 1 MEM
        // wait, add with 2 FETCH waits.
        run_instr(tbl[11], 0, 2);
        run_instr(tbl[12], 0, 1);
        run_instr(tbl[0], 2, 0);

        // Undefined opcode: trap is sticky and no strobes fire.
        cur_op = BAD_OP;
        mif.mem_ready = 1'b1; #1;
        chk("trap_fetch_irw", ir_write, 1);
        step();
        opcode = BAD_OP; #1;
        chk("trap_decode_state", state, 1);
        step();
        opcode = 5'b00000;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("trap_state", state, 7);
            chk("trap_flag", trap, 1);
            chk("trap_strobes", {mif.mem_req, ir_write, pc_write, reg_write, retire}, 0);
            chk("trap_count", instr_count, exp_count);
            step();
        end
        do_reset();
        #1;
        chk("post_trap_state", state, 0);
        chk("post_trap_flag", trap, 0);
        chk("post_trap_req", mif.mem_req, 1);

        // Counter wrap: retire j until the count is all-ones, then one more.
        vj = tbl[17];
        while (exp_count != {TB_CNT_W{1'b1}}) run_instr(vj, 0, 0);
        run_instr(vj, 0, 0);
        chk("count_wrap", instr_count, 0);

        // rst during a pending FETCH with mem_ready high.
        cur_op = 5'b00000;
        mif.mem_ready = 1'b1;
        rst = 1'b1; #1;
        chk("rst_fetch_req", mif.mem_req, 0);
        chk("rst_fetch_strobes", {ir_write, pc_write, reg_write, retire}, 0);
        step();
        rst = 1'b0; #1;
        chk("rst_fetch_count", instr_count, 0);
        chk("rst_fetch_state", state, 0);
        exp_count = '0;

        // rst during a pending sw MEM access.
        cur_op = 5'b11110;
        mif.mem_ready = 1'b1;
        step();
        opcode = 5'b11110;
        step();
        step(); #1;
        chk("sw_mem_reached", {state, mif.mem_we}, {3'd3, 1'b1});
        rst = 1'b1; #1;
        chk("rst_mem_req", {mif.mem_req, mif.mem_we, mif.iord}, 0);
        chk("rst_mem_retire", retire, 0);
        step();
        rst = 1'b0; #1;
        chk("rst_mem_count", instr_count, 0);
        chk("rst_mem_state", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
